// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: scans the enabled channels of a 4:1 mux in ascending order and publishes the Y captured at the end of each channel's dwell
module mux_channel_scanner #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_mask,
    input  logic       i_mux_y,
    output logic [1:0] o_address,
    output logic [3:0] o_sample,
    output logic       o_valid,
    output logic       o_busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_mask, r_shadow, r_sample, w_shadow_nxt, w_pending;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_address, w_addr_nxt, w_low;
    logic             r_valid, r_busy, w_capture;

    assign w_pending = (r_state == IDLE) ? i_mask : r_mask & (4'b1110 << r_address);
    assign w_low     = w_pending[0] ? 2'd0 : w_pending[1] ? 2'd1 : w_pending[2] ? 2'd2 : 2'd3;
    assign w_capture = (r_state == SCAN) && (r_cnt == CNT_W'(SETTLE_CYCLES - 1));

    always_comb begin
        w_state_nxt  = r_state;
        w_addr_nxt   = r_address;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        case (r_state)
            IDLE: if (i_start) begin
                w_cnt_nxt    = '0;
                w_shadow_nxt = '0;
                w_state_nxt  = (w_pending != 4'd0) ? SCAN : DONE;
                w_addr_nxt   = (w_pending != 4'd0) ? w_low : r_address;
            end
            SCAN: if (w_capture) begin
                w_shadow_nxt[r_address] = i_mux_y;
                w_cnt_nxt               = '0;
                w_state_nxt             = (w_pending != 4'd0) ? SCAN : DONE;
                w_addr_nxt              = (w_pending != 4'd0) ? w_low : r_address;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_address <= '0;
            r_cnt     <= '0;
            r_shadow  <= '0;
            r_mask    <= '0;
            r_sample  <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_address <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shadow  <= w_shadow_nxt;
            r_valid   <= (w_state_nxt == DONE);
            r_busy    <= (w_state_nxt != IDLE);
            if (r_state == IDLE && i_start)
                r_mask <= i_mask;
            // shadow only ever holds bits of scanned channels, so it is already masked
            if (w_state_nxt == DONE)
                r_sample <= w_shadow_nxt;
        end
    end

    assign o_address = r_address;
    assign o_sample  = r_sample;
    assign o_valid   = r_valid;
    assign o_busy    = r_busy;
endmodule

// File: tb/tb_mux_channel_scanner.sv
// tb_mux_channel_scanner: directed and randomized scans checked against a per-cycle model of the scan schedule
module tb_mux_channel_scanner;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst, start, mux_y, valid, busy;
    logic [3:0] mask, x, sample;
    logic [1:0] address;
    logic [1:0] m_addr;
    logic [3:0] m_sample;
    int         n_pass = 0;
    int         n_total = 0;

    always #5 clk = ~clk;
    assign mux_y = x[address];

    mux_channel_scanner #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mask(mask), .i_mux_y(mux_y),
        .o_address(address), .o_sample(sample), .o_valid(valid), .o_busy(busy)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_outs(input string tag, input logic [1:0] a, input logic [3:0] s,
                              input logic v, input logic b);
        check({tag, ".addr"}, 4'(address), 4'(a));
        check({tag, ".sample"}, sample, s);
        check({tag, ".valid"}, 4'(valid), 4'(v));
        check({tag, ".busy"}, 4'(busy), 4'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the current cycle; Start is sampled at its closing edge.
    task automatic run_scan(input logic [3:0] mk, input logic [3:0] xv, input bit hold, input bit jitter);
        int ch[4];
        int n = 0;
        int lat;
        logic [3:0] exp_s = 4'd0;
        for (int i = 0; i < 4; i++) if (mk[i]) begin ch[n] = i; n++; end
        lat = n * S + 1;
        mask = mk;
        x = xv;
        start = 1'b1;
        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            if (!hold) start = 1'b0;
            if (c <= n * S) begin
                m_addr = 2'(ch[(c - 1) / S]);
                check_outs("scan", m_addr, m_sample, 1'b0, 1'b1);
            end else if (c == lat) begin
                m_sample = exp_s;
                check_outs("done", m_addr, m_sample, 1'b1, 1'b1);
            end else begin
                check_outs("idle", m_addr, m_sample, 1'b0, 1'b0);
            end
            if (jitter) begin
                x = 4'($urandom);
                mask = 4'($urandom);
            end
            if (c % S == 0 && c <= n * S) exp_s[ch[c / S - 1]] = x[ch[c / S - 1]];
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mask = 4'd0; x = 4'd0;
        m_addr = 2'd0; m_sample = 4'd0;
        tick();
        tick();
        check_outs("reset", 2'd0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (5) begin
            tick();
            check_outs("quiet", 2'd0, 4'd0, 1'b0, 1'b0);
        end
        run_scan(4'b1111, 4'b1010, 1'b0, 1'b0);
        run_scan(4'b0101, 4'b1111, 1'b0, 1'b0);
        run_scan(4'b0000, 4'b1111, 1'b0, 1'b0);
        mask = 4'b1111; x = 4'b1111; start = 1'b1;
        tick();
        start = 1'b0;
        check_outs("abort.c1", 2'd0, m_sample, 1'b0, 1'b1);
        tick();
        tick();
        start = 1'b1;
        check_outs("abort.c3", 2'd1, m_sample, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        rst = 1'b1;
        check_outs("abort.c4", 2'd1, m_sample, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        m_addr = 2'd0;
        m_sample = 4'd0;
        repeat (12) begin
            check_outs("abort.after", 2'd0, 4'd0, 1'b0, 1'b0);
            tick();
        end
        run_scan(4'b0011, 4'b0001, 1'b1, 1'b0);
        run_scan(4'b0011, 4'b0001, 1'b1, 1'b0);
        start = 1'b0;
        repeat (20) run_scan(4'($urandom), 4'($urandom), 1'b0, 1'($urandom));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
